// File: rtl/tcb_lib_misalign_split.sv
// Splits a misaligned log-size TCB request into one or two aligned
// byte-enable transfers and merges the read data of a split pair back
// into a single in-order response.
module tcb_lib_misalign_split #(
    parameter  int AW  = 32,
    parameter  int DW  = 32,
    parameter  int OUT = 4,
    localparam int BEN = DW/8,
    localparam int MAX = $clog2(BEN),
    localparam int SW  = $clog2(MAX+1)
) (
    input  logic          clk,
    input  logic          rst,
    // subordinate side (log-size requests)
    input  logic          sub_vld,
    output logic          sub_rdy,
    input  logic          sub_wen,
    input  logic [AW-1:0] sub_adr,
    input  logic [SW-1:0] sub_siz,
    input  logic [DW-1:0] sub_wdt,
    output logic          sub_rsp_vld,
    output logic [DW-1:0] sub_rdt,
    output logic          sub_sts,
    // manager side (aligned byte-enable transfers)
    output logic          man_vld,
    input  logic          man_rdy,
    output logic          man_wen,
    output logic [AW-1:0] man_adr,
    output logic [BEN-1:0] man_ben,
    output logic [DW-1:0] man_wdt,
    input  logic          man_rsp_vld,
    input  logic [DW-1:0] man_rdt,
    input  logic          man_sts
);

    localparam int PW = $clog2(OUT);

    typedef enum logic [1:0] {
        KIND_SINGLE = 2'd0,
        KIND_FIRST  = 2'd1,
        KIND_SECOND = 2'd2
    } kind_t;

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    typedef struct packed {
        kind_t          kind;
        logic [MAX-1:0] off;
        logic [SW-1:0]  siz;
    } tag_t;

    state_t          state;
    state_t          state_nxt;

    logic [MAX-1:0]  off;
    logic [MAX+1:0]  end_pos;
    logic            split;
    logic [AW-1:0]   base_adr;
    logic [BEN-1:0]  ben_first;
    logic [BEN-1:0]  ben_second;
    logic [DW-1:0]   wdt_lanes;

    tag_t            fifo_mem [OUT];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW:0]     fifo_cnt;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    kind_t           push_kind;
    tag_t            push_tag;
    tag_t            rsp_tag;

    logic [DW-1:0]   hold_rdt;
    logic            hold_sts;

    // Request geometry: end_pos is one past the last byte lane touched,
    // counted from the first word, so anything above BEN spills over.
    assign off      = sub_adr[MAX-1:0];
    assign end_pos  = (MAX+2)'(off) + ((MAX+2)'(1) << sub_siz);
    assign split    = end_pos > (MAX+2)'(BEN);
    assign base_adr = {sub_adr[AW-1:MAX], {MAX{1'b0}}};

    // A full FIFO still accepts a push in a cycle where a response pops a tag.
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PW+1)'(OUT)) && !man_rsp_vld;
    assign push       = man_vld && man_rdy;
    assign pop        = man_rsp_vld && !fifo_empty;
    assign push_tag   = {push_kind, off, sub_siz};
    assign rsp_tag    = fifo_mem[rd_ptr[PW-1:0]];

    // Byte enables for both halves and the rotated write-data lanes.
    always_comb begin
        ben_first  = '0;
        ben_second = '0;
        wdt_lanes  = '0;
        for (int i = 0; i < BEN; i++) begin
            ben_first[i]  = (i >= int'(off)) && (i < int'(end_pos));
            ben_second[i] = (i + BEN) < int'(end_pos);
            wdt_lanes[8*i +: 8] = sub_wdt[8*((i + BEN - int'(off)) % BEN) +: 8];
        end
    end

    // FSM state register; reset always lands in FIRST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and manager request; the subordinate is only released on
    // the handshake that completes its whole request.
    always_comb begin
        state_nxt = state;
        man_vld   = 1'b0;
        man_wen   = 1'b0;
        man_adr   = '0;
        man_ben   = '0;
        man_wdt   = '0;
        sub_rdy   = 1'b0;
        push_kind = KIND_SINGLE;
        if (!rst) begin
            man_vld = sub_vld && !fifo_full;
            man_wen = sub_wen;
            man_wdt = wdt_lanes;
            case (state)
                ST_FIRST: begin
                    man_adr = base_adr;
                    man_ben = ben_first;
                    if (split) begin
                        push_kind = KIND_FIRST;
                        if (man_vld && man_rdy) begin
                            state_nxt = ST_SECOND;
                        end
                    end else begin
                        push_kind = KIND_SINGLE;
                        sub_rdy   = man_rdy && !fifo_full;
                    end
                end
                ST_SECOND: begin
                    man_adr   = base_adr + AW'(BEN);
                    man_ben   = ben_second;
                    push_kind = KIND_SECOND;
                    sub_rdy   = man_rdy && !fifo_full;
                    if (man_vld && man_rdy) begin
                        state_nxt = ST_FIRST;
                    end
                end
                default: begin
                    state_nxt = ST_FIRST;
                end
            endcase
        end
    end

    // Tag FIFO: one entry per manager transfer, retired by its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PW-1:0]] <= push_tag;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Hold the first-half response until its second half arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_rdt <= '0;
            hold_sts <= 1'b0;
        end else if (pop && (rsp_tag.kind == KIND_FIRST)) begin
            hold_rdt <= man_rdt;
            hold_sts <= man_sts;
        end
    end

    // Combinational response merge, LSB-justified and zero above size.
    always_comb begin
        sub_rsp_vld = 1'b0;
        sub_rdt     = '0;
        sub_sts     = 1'b0;
        if (!rst && pop) begin
            case (rsp_tag.kind)
                KIND_SINGLE: begin
                    sub_rsp_vld = 1'b1;
                    sub_sts     = man_sts;
                    for (int j = 0; j < BEN; j++) begin
                        if (j < (1 << rsp_tag.siz)) begin
                            sub_rdt[8*j +: 8] = man_rdt[8*((j + int'(rsp_tag.off)) % BEN) +: 8];
                        end
                    end
                end
                KIND_SECOND: begin
                    sub_rsp_vld = 1'b1;
                    sub_sts     = hold_sts | man_sts;
                    for (int j = 0; j < BEN; j++) begin
                        if (j < (1 << rsp_tag.siz)) begin
                            if ((j + int'(rsp_tag.off)) < BEN) begin
                                sub_rdt[8*j +: 8] = hold_rdt[8*(j + int'(rsp_tag.off)) +: 8];
                            end else begin
                                sub_rdt[8*j +: 8] = man_rdt[8*(j + int'(rsp_tag.off) - BEN) +: 8];
                            end
                        end
                    end
                end
                default: begin
                    sub_rsp_vld = 1'b0;
                end
            endcase
        end
    end

    // A response with no outstanding transfer breaks the protocol.
    rsp_without_tag: assert property (@(posedge clk) disable iff (rst)
        man_rsp_vld |-> !fifo_empty);

endmodule

// File: tb/tb_tcb_lib_misalign_split.sv
// Scoreboard bench for tcb_lib_misalign_split: a byte-addressed memory
// model predicts transfers and responses, a separate monitor compares.
module tb_tcb_lib_misalign_split;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int OUT = 4;
    localparam int BEN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sub_vld;
    logic          sub_rdy;
    logic          sub_wen;
    logic [AW-1:0] sub_adr;
    logic [1:0]    sub_siz;
    logic [DW-1:0] sub_wdt;
    logic          sub_rsp_vld;
    logic [DW-1:0] sub_rdt;
    logic          sub_sts;
    logic          man_vld;
    logic          man_rdy;
    logic          man_wen;
    logic [AW-1:0] man_adr;
    logic [BEN-1:0] man_ben;
    logic [DW-1:0] man_wdt;
    logic          man_rsp_vld;
    logic [DW-1:0] man_rdt;
    logic          man_sts;

    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } xfer_t;

    typedef struct packed {
        logic [31:0] rdt;
        logic        sts;
    } rsp_t;

    xfer_t exp_man[$];
    rsp_t  exp_rsp[$];
    rsp_t  pending[$];

    logic [7:0] ref_mem [logic [31:0]];
    logic [7:0] rsp_mem [logic [31:0]];
    bit         err_word [logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode;
    int rsp_mode;
    bit rsp_shot;

    tcb_lib_misalign_split #(.AW(AW), .DW(DW), .OUT(OUT)) dut (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_rdy(sub_rdy), .sub_wen(sub_wen),
        .sub_adr(sub_adr), .sub_siz(sub_siz), .sub_wdt(sub_wdt),
        .sub_rsp_vld(sub_rsp_vld), .sub_rdt(sub_rdt), .sub_sts(sub_sts),
        .man_vld(man_vld), .man_rdy(man_rdy), .man_wen(man_wen),
        .man_adr(man_adr), .man_ben(man_ben), .man_wdt(man_wdt),
        .man_rsp_vld(man_rsp_vld), .man_rdt(man_rdt), .man_sts(man_sts)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rsp_rd(input logic [31:0] a);
        return rsp_mem.exists(a) ? rsp_mem[a] : init_byte(a);
    endfunction

    function automatic logic [127:0] out_vec();
        return {sub_rdy, man_vld, man_wen, man_adr, man_ben, man_wdt,
                sub_rsp_vld, sub_rdt, sub_sts};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got,
                               input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Present a request and predict the aligned word transfers it covers.
    task automatic start_req(input logic wen, input logic [31:0] adr,
                             input logic [1:0] siz, input logic [31:0] wdt);
        xfer_t       t0;
        xfer_t       t1;
        logic [31:0] base;
        logic [31:0] a;
        int          n;
        sub_wen = wen;
        sub_adr = adr;
        sub_siz = siz;
        sub_wdt = wdt;
        sub_vld = 1'b1;
        n    = 1 << siz;
        base = adr & ~32'h3;
        t0 = '0;
        t1 = '0;
        t0.wen = wen;
        t1.wen = wen;
        t0.adr = base;
        t1.adr = base + 32'd4;
        for (int k = 0; k < BEN; k++) begin
            t0.wdt[8*((int'(adr[1:0]) + k) % BEN) +: 8] = wdt[8*k +: 8];
        end
        t1.wdt = t0.wdt;
        for (int k = 0; k < n; k++) begin
            a = adr + 32'(k);
            if ((a & ~32'h3) == base) t0.ben[a[1:0]] = 1'b1;
            else                      t1.ben[a[1:0]] = 1'b1;
        end
        exp_man.push_back(t0);
        if (t1.ben != 4'b0000) exp_man.push_back(t1);
    endtask

    // Commit the accepted request to the reference memory and predict its response.
    task automatic accept_req();
        rsp_t        r;
        logic [31:0] a;
        r = '0;
        for (int k = 0; k < (1 << sub_siz); k++) begin
            a = sub_adr + 32'(k);
            if (sub_wen) ref_mem[a] = sub_wdt[8*k +: 8];
            r.rdt[8*k +: 8] = ref_rd(a);
            if (err_word.exists(a & ~32'h3)) r.sts = 1'b1;
        end
        exp_rsp.push_back(r);
    endtask

    task automatic applyStimulus(input logic wen, input logic [31:0] adr,
                                 input logic [1:0] siz, input logic [31:0] wdt,
                                 output int cycles);
        start_req(wen, adr, siz, wdt);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!sub_rdy && cycles < 200);
        if (sub_rdy) begin
            accept_req();
        end else begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: no sub_rdy after %0d cycles, required within 200 (adr 0x%0h)", cycles, adr);
        end
        @(posedge clk);
        #1;
        sub_vld = 1'b0;
    endtask

    task automatic drain();
        rsp_mode = 2;
        for (int k = 0; k < 500 && (exp_rsp.size() != 0 || pending.size() != 0); k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_outstanding", exp_rsp.size() + exp_man.size() + pending.size(), 0);
    endtask

    // Manager ready pattern: always ready or randomly throttled.
    initial begin
        man_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            man_rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Manager responder: returns queued responses in order.
    initial begin
        rsp_t r;
        man_rsp_vld = 1'b0;
        man_rdt     = '0;
        man_sts     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            man_rsp_vld = 1'b0;
            man_sts     = 1'b0;
            man_rdt     = $urandom;
            if (!rst && pending.size() != 0 &&
                (rsp_mode == 2 || rsp_shot || (rsp_mode == 1 && $urandom_range(0, 1) == 1))) begin
                r           = pending.pop_front();
                man_rsp_vld = 1'b1;
                man_rdt     = r.rdt;
                man_sts     = r.sts;
                rsp_shot    = 1'b0;
            end
        end
    end

    // Monitor: checks every manager transfer and every subordinate response.
    initial begin
        xfer_t       e;
        rsp_t        er;
        rsp_t        nr;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (man_vld && man_rdy) begin
                if (exp_man.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL man_xfer: unexpected transfer adr 0x%0h ben %b, required none", man_adr, man_ben);
                end else begin
                    e = exp_man.pop_front();
                    checkOutput("man_xfer", {man_wen, man_adr, man_ben, man_wen ? man_wdt : 32'h0},
                                {e.wen, e.adr, e.ben, e.wen ? e.wdt : 32'h0});
                end
                if (man_wen) begin
                    for (int i = 0; i < BEN; i++) begin
                        if (man_ben[i]) rsp_mem[man_adr + 32'(i)] = man_wdt[8*i +: 8];
                    end
                end
                for (int i = 0; i < BEN; i++) nr.rdt[8*i +: 8] = rsp_rd(man_adr + 32'(i));
                nr.sts = err_word.exists(man_adr);
                pending.push_back(nr);
            end
            if (sub_rsp_vld) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sub_rsp: unexpected response rdt 0x%0h, required none", sub_rdt);
                end else begin
                    er = exp_rsp.pop_front();
                    checkOutput("sub_rsp", {sub_sts, sub_rdt}, {er.sts, er.rdt});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc;
        logic [31:0] a;
        rst      = 1'b1;
        sub_vld  = 1'b1;
        sub_wen  = 1'b1;
        sub_adr  = 32'h123;
        sub_siz  = 2'd2;
        sub_wdt  = 32'hFFFF_FFFF;
        rdy_mode = 0;
        rsp_mode = 2;
        rsp_shot = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_values", out_vec(), 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        sub_vld = 1'b0;

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 32'h100, 2'd2, 32'hDDCC_BBAA, cyc);
        applyStimulus(1'b0, 32'h100, 2'd2, 32'h0, cyc);
        checkOutput("aligned_read_cycles", cyc, 1);
        applyStimulus(1'b1, 32'h101, 2'd1, 32'h0000_BEEF, cyc);
        checkOutput("unsplit_write_same_cycle", cyc, 1);
        applyStimulus(1'b1, 32'h103, 2'd2, 32'h4433_2211, cyc);
        checkOutput("split_write_two_cycles", cyc, 2);
        applyStimulus(1'b1, 32'h104, 2'd2, 32'h8877_6655, cyc);
        applyStimulus(1'b0, 32'h102, 2'd2, 32'h0, cyc);
        checkOutput("split_read_two_cycles", cyc, 2);
        err_word[32'h200] = 1'b1;
        applyStimulus(1'b0, 32'h202, 2'd2, 32'h0, cyc);
        applyStimulus(1'b0, 32'h206, 2'd1, 32'h0, cyc);
        applyStimulus(1'b1, 32'hFFFF_FFFE, 2'd2, 32'hA1B2_C3D4, cyc);
        applyStimulus(1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0, cyc);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 2'd0, 32'h0, cyc);
        drain();

        $display("[TB] tag FIFO full");
        rsp_mode = 0;
        for (int k = 0; k < OUT; k++) begin
            applyStimulus(1'b0, 32'h100 + 32'(4*k), 2'd2, 32'h0, cyc);
        end
        start_req(1'b0, 32'h110, 2'd2, 32'h0);
        @(negedge clk);
        checkOutput("fifo_full_stalls", {man_vld, sub_rdy}, 2'b00);
        rsp_shot = 1'b1;
        @(negedge clk);
        checkOutput("full_pop_and_push", {man_vld, sub_rdy, man_rsp_vld}, 3'b111);
        if (sub_rdy) accept_req();
        @(posedge clk);
        #1;
        sub_vld = 1'b0;
        drain();

        $display("[TB] reset during second half");
        rsp_mode = 0;
        start_req(1'b0, 32'h102, 2'd2, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_man.delete();
        exp_rsp.delete();
        pending.delete();
        @(negedge clk);
        checkOutput("reset_in_second", out_vec(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h102, 2'd2, 32'h0, cyc);
        checkOutput("after_reset_split_cycles", cyc, 2);
        applyStimulus(1'b0, 32'h108, 2'd2, 32'h0, cyc);
        checkOutput("after_reset_fifo_room_a", cyc, 1);
        applyStimulus(1'b0, 32'h10C, 2'd2, 32'h0, cyc);
        checkOutput("after_reset_fifo_room_b", cyc, 1);
        drain();

        $display("[TB] random traffic");
        rdy_mode = 1;
        rsp_mode = 1;
        err_word[32'h308] = 1'b1;
        err_word[32'h314] = 1'b1;
        repeat (300) begin
            a = 32'h300 + 32'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 2)), $urandom, cyc);
            rsp_mode = 1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
